// File: rtl/timer_pkg.sv
// Shared definitions for the timer block: FSM state encoding and the default expiry length.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } timer_state_e;

  localparam int unsigned TIMER_MAX_DEFAULT = 3500;

endpackage

// File: rtl/timer.sv
// Expiry timer: timer_out rises after MAX consecutive enabled edges and holds while enabled.
// Define TIMER_STATUS_EN to expose the running count on timer_cnt.
module timer
  import timer_pkg::*;
#(
  parameter  int unsigned MAX = TIMER_MAX_DEFAULT,
  localparam int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          timer_ena,
  input  logic          timer_rst,
`ifdef TIMER_STATUS_EN
  output logic [CW-1:0] timer_cnt,
`endif
  output logic          timer_out
);

  localparam logic [CW-1:0] MaxCount = CW'(MAX);

  timer_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  // Clear wins over enable; a low enable restarts the interval rather than pausing it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (timer_rst || !timer_ena) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = CW'(1);
          state_d = (MAX == 1) ? DONE : COUNT;
        end
        COUNT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == MaxCount) state_d = DONE;
        end
        DONE: begin
          cnt_d = MaxCount;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    out_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign timer_out = out_q;
`ifdef TIMER_STATUS_EN
  assign timer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: three instances (MAX = 3500, 10, 1) share one stimulus stream.
// Count checks are active only when TIMER_STATUS_EN is defined.
module tb_timer;
  import timer_pkg::*;

  typedef struct packed {
    logic [2:0]  out;
    logic [23:0] c0;
    logic [23:0] c1;
    logic [23:0] c2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic timer_ena;
  logic timer_rst;
  logic out0, out1, out2;
`ifdef TIMER_STATUS_EN
  logic [11:0] cnt0;
  logic [3:0]  cnt1;
  logic [0:0]  cnt2;
`endif

  int   maxTab[3] = '{TIMER_MAX_DEFAULT, 10, 1};
  int   runLen[3];
  exp_t scoreQ[$];
  exp_t monE;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  timer u3500 (
    .clk(clk), .rst_n(rst_n), .timer_ena(timer_ena), .timer_rst(timer_rst),
`ifdef TIMER_STATUS_EN
    .timer_cnt(cnt0),
`endif
    .timer_out(out0)
  );

  timer #(.MAX(10)) u10 (
    .clk(clk), .rst_n(rst_n), .timer_ena(timer_ena), .timer_rst(timer_rst),
`ifdef TIMER_STATUS_EN
    .timer_cnt(cnt1),
`endif
    .timer_out(out1)
  );

  timer #(.MAX(1)) u1 (
    .clk(clk), .rst_n(rst_n), .timer_ena(timer_ena), .timer_rst(timer_rst),
`ifdef TIMER_STATUS_EN
    .timer_cnt(cnt2),
`endif
    .timer_out(out2)
  );

  task automatic checkBit(input string name, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkBit("out_max3500", out0, e.out[0]);
    checkBit("out_max10", out1, e.out[1]);
    checkBit("out_max1", out2, e.out[2]);
`ifdef TIMER_STATUS_EN
    checkCount("cnt_max3500", int'(cnt0), int'(e.c0));
    checkCount("cnt_max10", int'(cnt1), int'(e.c1));
    checkCount("cnt_max1", int'(cnt2), int'(e.c2));
`endif
  endtask

  // Model: count of consecutive enabled edges since the last clear, capped at MAX.
  task automatic applyStimulus(input logic ena, input logic rst);
    exp_t e;
    @(negedge clk);
    timer_ena = ena;
    timer_rst = rst;
    for (int i = 0; i < 3; i++) begin
      if (rst || !ena) runLen[i] = 0;
      else if (runLen[i] < maxTab[i]) runLen[i] = runLen[i] + 1;
      e.out[i] = (runLen[i] >= maxTab[i]);
    end
    e.c0 = 24'(runLen[0]);
    e.c1 = 24'(runLen[1]);
    e.c2 = 24'(runLen[2]);
    scoreQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_out_max3500"}, out0, 1'b0);
    checkBit({tag, "_out_max10"}, out1, 1'b0);
    checkBit({tag, "_out_max1"}, out2, 1'b0);
`ifdef TIMER_STATUS_EN
    checkCount({tag, "_cnt_max3500"}, int'(cnt0), 0);
    checkCount({tag, "_cnt_max10"}, int'(cnt1), 0);
    checkCount({tag, "_cnt_max1"}, int'(cnt2), 0);
`endif
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  // Monitor: every cycle out of reset the DUTs present outputs; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && scoreQ.size() > 0) begin
      monE = scoreQ.pop_front();
      checkOutput(monE);
    end
  end

  initial begin
    #1_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    printSummary();
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    timer_ena = 1'b0;
    timer_rst = 1'b0;
    for (int i = 0; i < 3; i++) runLen[i] = 0;
    #3;
    checkAllZero("reset");
    #9;
    rst_n = 1'b1;

    $display("[TB] random enable/clear phase");
    for (int n = 0; n < 300; n++)
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));

    $display("[TB] long enable run past MAX=3500");
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 3520; n++) applyStimulus(1'b1, 1'b0);

    $display("[TB] 2000 enabled edges, one low edge, then full restart");
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 2000; n++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 3510; n++) applyStimulus(1'b1, 1'b0);

    $display("[TB] synchronous clear at edge 7 and in DONE");
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 6; n++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 12; n++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-count");
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) runLen[i] = 0;
    #1;
    checkAllZero("async");
    @(posedge clk);
    #2;
    checkAllZero("held");
    timer_ena = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 200; n++)
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));

    @(posedge clk);
    #3;
    compared++;
    if (scoreQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreQ.size());
    end
    printSummary();
    $finish;
  end

endmodule
